// File: rtl/coherence_bus_ctrl_pkg.sv
// Shared encodings for the snoopy coherence bus.
// The cpu-side cache controller uses the same bus_op_t and datasel_t values.
package coherence_bus_ctrl_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    NONE    = 2'b00,
    BUSRD   = 2'b01,
    BUSRDX  = 2'b10,
    BUSUPGR = 2'b11
  } bus_op_t;

  typedef enum logic [1:0] {
    DS_NONE = 2'b00,
    DS_CPU  = 2'b01,
    DS_MEM  = 2'b10
  } datasel_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SNOOP = 2'b01,
    RESP  = 2'b10,
    HOLD  = 2'b11
  } state_t;

  // A cpu raising several request lines at once is served by the strongest
  // one: write_miss beats read_miss, which beats invalidate.
  function automatic bus_op_t pick_op(input logic rm, input logic wm, input logic iv);
    bus_op_t op;
    op = NONE;
    if (wm)      op = BUSRDX;
    else if (rm) op = BUSRD;
    else if (iv) op = BUSUPGR;
    return op;
  endfunction

endpackage

// File: rtl/coherence_bus_ctrl_if.sv
// One cpu's coherence link to the bus controller.
// master = cpu cache side, slave = bus controller side.
interface coherence_bus_ctrl_if #(
  parameter int ADDR_W = 11
);

  logic              read_miss;
  logic              write_miss;
  logic              invalidate;
  logic [ADDR_W-1:0] BICO;
  logic              cpu_search_found;
  logic [15:0]       send_other_proc_data;

  logic              grant;
  logic              cpu_search;
  logic [ADDR_W+1:0] BOCI;
  logic [1:0]        cpu_datasel;
  logic              invalidate_from_other_cpu;
  logic [15:0]       other_proc_data;

  modport master (
    output read_miss, write_miss, invalidate, BICO, cpu_search_found, send_other_proc_data,
    input  grant, cpu_search, BOCI, cpu_datasel, invalidate_from_other_cpu, other_proc_data
  );

  modport slave (
    input  read_miss, write_miss, invalidate, BICO, cpu_search_found, send_other_proc_data,
    output grant, cpu_search, BOCI, cpu_datasel, invalidate_from_other_cpu, other_proc_data
  );

endinterface

// File: rtl/coherence_bus_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter. The pointer names the favoured cpu and
// moves to the cpu that was not served whenever advance pulses.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  input  logic       served,
  output logic       winner
);

  logic ptr;

  // Pointer update: after a transaction the other cpu gets first claim.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ptr <= 1'b0;
    else if (advance) ptr <= ~served;
  end

  // Only a tie consults the pointer; a lone requester always wins.
  always_comb begin
    winner = req[1];
    if (req == 2'b11) winner = ptr;
  end

endmodule

// File: rtl/coherence_bus_ctrl.sv
// Snoopy bus responder for two cpus: arbitrate, snoop the other cache,
// then grant with a data-source select and optional invalidate.
// Optional build macro COH_STATS_EN adds saturating txn_cnt / c2c_cnt outputs.
module coherence_bus_ctrl
  import coherence_bus_ctrl_pkg::*;
#(
  parameter int SNOOP_LAT = 1,
  parameter int ADDR_W    = 11
) (
  input  logic clk,
  input  logic rst_n,
  coherence_bus_ctrl_if.slave cpu0,
  coherence_bus_ctrl_if.slave cpu1
`ifdef COH_STATS_EN
  ,
  output logic [15:0] txn_cnt,
  output logic [15:0] c2c_cnt
`endif
);

  localparam logic [2:0] LAST = 3'(SNOOP_LAT - 1);

  logic [1:0]        req;
  bus_op_t           op_in   [2];
  logic [ADDR_W-1:0] addr_in [2];
  logic [1:0]        found_in;
  logic [DATA_W-1:0] data_in [2];

  state_t            state, state_d;
  logic              winner_q, arb_winner, other;
  bus_op_t           op_q;
  logic [ADDR_W-1:0] addr_q;
  logic              found_q;
  logic [DATA_W-1:0] data_q;
  logic [2:0]        cnt;
  logic              snoop_done;
  datasel_t          ds;

  logic [1:0]        grant_o, search_o, inv_o;
  logic [ADDR_W+1:0] boci_o  [2];
  logic [1:0]        ds_o    [2];
  logic [DATA_W-1:0] pdata_o [2];

  assign req[0]      = cpu0.read_miss | cpu0.write_miss | cpu0.invalidate;
  assign req[1]      = cpu1.read_miss | cpu1.write_miss | cpu1.invalidate;
  assign op_in[0]    = pick_op(cpu0.read_miss, cpu0.write_miss, cpu0.invalidate);
  assign op_in[1]    = pick_op(cpu1.read_miss, cpu1.write_miss, cpu1.invalidate);
  assign addr_in[0]  = cpu0.BICO;
  assign addr_in[1]  = cpu1.BICO;
  assign found_in[0] = cpu0.cpu_search_found;
  assign found_in[1] = cpu1.cpu_search_found;
  assign data_in[0]  = cpu0.send_other_proc_data;
  assign data_in[1]  = cpu1.send_other_proc_data;

  assign other      = ~winner_q;
  assign snoop_done = (cnt == LAST);

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .advance (state == RESP),
    .served  (winner_q),
    .winner  (arb_winner)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Next state: a HOLD only ends once the winner has released every request line.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (|req) state_d = SNOOP;
      SNOOP:   if (snoop_done) state_d = RESP;
      RESP:    state_d = HOLD;
      HOLD:    if (!req[winner_q]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Transaction capture in IDLE, snoop timer, and snoop result on the last SNOOP edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      winner_q <= 1'b0;
      op_q     <= NONE;
      addr_q   <= '0;
      found_q  <= 1'b0;
      data_q   <= '0;
      cnt      <= '0;
    end else begin
      if (state == IDLE && |req) begin
        winner_q <= arb_winner;
        op_q     <= op_in[arb_winner];
        addr_q   <= addr_in[arb_winner];
        cnt      <= '0;
      end
      if (state == SNOOP) begin
        if (snoop_done) begin
          found_q <= found_in[other];
          data_q  <= data_in[other];
        end else begin
          cnt <= cnt + 3'd1;
        end
      end
    end
  end

  // Data source: misses take the other cache's copy on a hit, memory otherwise;
  // an upgrade needs no data.
  always_comb begin
    ds = DS_NONE;
    if (op_q == BUSRD || op_q == BUSRDX) ds = found_q ? DS_CPU : DS_MEM;
  end

  // Bus outputs decoded from the registered state so everything clears with reset.
  always_comb begin
    grant_o  = '0;
    search_o = '0;
    inv_o    = '0;
    for (int i = 0; i < 2; i++) begin
      boci_o[i]  = '0;
      ds_o[i]    = '0;
      pdata_o[i] = '0;
    end
    if (state == SNOOP) begin
      search_o[other] = 1'b1;
      boci_o[other]   = {op_q, addr_q};
    end
    if (state == RESP) begin
      grant_o[winner_q] = 1'b1;
      inv_o[other]      = (op_q == BUSRDX) || (op_q == BUSUPGR);
    end
    if (state == RESP || state == HOLD) begin
      ds_o[winner_q] = ds;
      if (ds == DS_CPU) pdata_o[winner_q] = data_q;
    end
  end

  assign cpu0.grant                     = grant_o[0];
  assign cpu0.cpu_search                = search_o[0];
  assign cpu0.BOCI                      = boci_o[0];
  assign cpu0.cpu_datasel               = ds_o[0];
  assign cpu0.invalidate_from_other_cpu = inv_o[0];
  assign cpu0.other_proc_data           = pdata_o[0];
  assign cpu1.grant                     = grant_o[1];
  assign cpu1.cpu_search                = search_o[1];
  assign cpu1.BOCI                      = boci_o[1];
  assign cpu1.cpu_datasel               = ds_o[1];
  assign cpu1.invalidate_from_other_cpu = inv_o[1];
  assign cpu1.other_proc_data           = pdata_o[1];

`ifdef COH_STATS_EN
  // Saturating counters of responses and of cache-to-cache transfers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txn_cnt <= '0;
      c2c_cnt <= '0;
    end else if (state == RESP) begin
      if (txn_cnt != 16'hFFFF) txn_cnt <= txn_cnt + 16'd1;
      if (ds == DS_CPU && c2c_cnt != 16'hFFFF) c2c_cnt <= c2c_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Bench for coherence_bus_ctrl: two instances (SNOOP_LAT 1 and 3) see the same
// cpu stimulus and are compared every cycle against a transaction-level model.
module tb_coherence_bus_ctrl;

  logic clk;
  logic rst_n;

  logic        rm [2];
  logic        wm [2];
  logic        iv [2];
  logic [10:0] bico [2];
  logic        found [2];
  logic [15:0] sdata [2];

  int tests_run    = 0;
  int tests_failed = 0;

  coherence_bus_ctrl_if #(.ADDR_W(11)) if1_0 ();
  coherence_bus_ctrl_if #(.ADDR_W(11)) if1_1 ();
  coherence_bus_ctrl_if #(.ADDR_W(11)) if3_0 ();
  coherence_bus_ctrl_if #(.ADDR_W(11)) if3_1 ();

  assign if1_0.read_miss = rm[0];   assign if1_1.read_miss = rm[1];
  assign if3_0.read_miss = rm[0];   assign if3_1.read_miss = rm[1];
  assign if1_0.write_miss = wm[0];  assign if1_1.write_miss = wm[1];
  assign if3_0.write_miss = wm[0];  assign if3_1.write_miss = wm[1];
  assign if1_0.invalidate = iv[0];  assign if1_1.invalidate = iv[1];
  assign if3_0.invalidate = iv[0];  assign if3_1.invalidate = iv[1];
  assign if1_0.BICO = bico[0];      assign if1_1.BICO = bico[1];
  assign if3_0.BICO = bico[0];      assign if3_1.BICO = bico[1];
  assign if1_0.cpu_search_found = found[0];  assign if1_1.cpu_search_found = found[1];
  assign if3_0.cpu_search_found = found[0];  assign if3_1.cpu_search_found = found[1];
  assign if1_0.send_other_proc_data = sdata[0];  assign if1_1.send_other_proc_data = sdata[1];
  assign if3_0.send_other_proc_data = sdata[0];  assign if3_1.send_other_proc_data = sdata[1];

`ifdef COH_STATS_EN
  logic [15:0] txn1, c2c1, txn3, c2c3;
`endif

  coherence_bus_ctrl #(.SNOOP_LAT(1), .ADDR_W(11)) dut1 (
    .clk (clk), .rst_n (rst_n), .cpu0 (if1_0), .cpu1 (if1_1)
`ifdef COH_STATS_EN
    , .txn_cnt (txn1), .c2c_cnt (c2c1)
`endif
  );

  coherence_bus_ctrl #(.SNOOP_LAT(3), .ADDR_W(11)) dut3 (
    .clk (clk), .rst_n (rst_n), .cpu0 (if3_0), .cpu1 (if3_1)
`ifdef COH_STATS_EN
    , .txn_cnt (txn3), .c2c_cnt (c2c3)
`endif
  );

  logic [33:0] obs [2][2];
  assign obs[0][0] = {if1_0.grant, if1_0.cpu_search, if1_0.BOCI, if1_0.cpu_datasel, if1_0.invalidate_from_other_cpu, if1_0.other_proc_data};
  assign obs[0][1] = {if1_1.grant, if1_1.cpu_search, if1_1.BOCI, if1_1.cpu_datasel, if1_1.invalidate_from_other_cpu, if1_1.other_proc_data};
  assign obs[1][0] = {if3_0.grant, if3_0.cpu_search, if3_0.BOCI, if3_0.cpu_datasel, if3_0.invalidate_from_other_cpu, if3_0.other_proc_data};
  assign obs[1][1] = {if3_1.grant, if3_1.cpu_search, if3_1.BOCI, if3_1.cpu_datasel, if3_1.invalidate_from_other_cpu, if3_1.other_proc_data};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: one transaction record per instance, with k counting
  // cycles since the accepting edge (snoop for k=1..L, response at L+1, hold after).
  int          lat_of [2] = '{1, 3};
  bit          m_busy [2];
  int          m_k    [2];
  bit          m_win  [2];
  int          m_op   [2];
  logic [10:0] m_addr [2];
  bit          m_found[2];
  logic [15:0] m_data [2];
  bit          m_ptr  [2];
  int          m_txn  [2];
  int          m_c2c  [2];

  function automatic bit anyreq(input bit c);
    return rm[c] | wm[c] | iv[c];
  endfunction

  task automatic modelReset();
    for (int m = 0; m < 2; m++) begin
      m_busy[m] = 0; m_k[m] = 0; m_ptr[m] = 0; m_txn[m] = 0; m_c2c[m] = 0;
    end
  endtask

  task automatic modelEdge();
    bit w;
    int L;
    for (int m = 0; m < 2; m++) begin
      L = lat_of[m];
      if (!m_busy[m]) begin
        if (anyreq(0) || anyreq(1)) begin
          w = (anyreq(0) && anyreq(1)) ? m_ptr[m] : anyreq(1);
          m_win[m]  = w;
          m_op[m]   = wm[w] ? 2 : (rm[w] ? 1 : 3);
          m_addr[m] = bico[w];
          m_busy[m] = 1;
          m_k[m]    = 1;
        end
      end else begin
        w = m_win[m];
        if (m_k[m] == L) begin
          m_found[m] = found[!w];
          m_data[m]  = sdata[!w];
        end
        if (m_k[m] == L + 1) begin
          m_ptr[m] = !w;
          if (m_txn[m] < 65535) m_txn[m]++;
          if (m_op[m] <= 2 && m_found[m] && m_c2c[m] < 65535) m_c2c[m]++;
        end
        if (m_k[m] >= L + 2 && !anyreq(w)) m_busy[m] = 0;
        m_k[m]++;
      end
    end
  endtask

  function automatic logic [33:0] expOut(input int m, input int c);
    int          L      = lat_of[m];
    int          k      = m_k[m];
    bit          isw    = (c == int'(m_win[m]));
    bit          snoop  = m_busy[m] && k >= 1 && k <= L;
    bit          resp   = m_busy[m] && k == L + 1;
    bit          after  = m_busy[m] && k >= L + 1;
    bit          rdlike = (m_op[m] == 1) || (m_op[m] == 2);
    logic [1:0]  ds     = 2'b00;
    logic [12:0] boci   = '0;
    logic [15:0] d      = '0;
    bit          g, s, inv;
    if (after && isw && rdlike) ds = m_found[m] ? 2'b01 : 2'b10;
    if (ds == 2'b01) d = m_data[m];
    g = resp && isw;
    s = snoop && !isw;
    if (s) boci = {2'(m_op[m]), m_addr[m]};
    inv = resp && !isw && (m_op[m] >= 2);
    return {g, s, boci, ds, inv, d};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic checkAll();
    for (int m = 0; m < 2; m++)
      for (int c = 0; c < 2; c++)
        checkOutput($sformatf("lat%0d_cpu%0d", lat_of[m], c), 64'(obs[m][c]), 64'(expOut(m, c)));
`ifdef COH_STATS_EN
    checkOutput("txn_lat1", 64'(txn1), 64'(m_txn[0]));
    checkOutput("c2c_lat1", 64'(c2c1), 64'(m_c2c[0]));
    checkOutput("txn_lat3", 64'(txn3), 64'(m_txn[1]));
    checkOutput("c2c_lat3", 64'(c2c3), 64'(m_c2c[1]));
`endif
  endtask

  // r = {write_miss, read_miss, invalidate} per cpu.
  task automatic applyStimulus(input logic [2:0] r0, input logic [2:0] r1,
                               input logic [10:0] a0, input logic [10:0] a1,
                               input logic f0, input logic f1,
                               input logic [15:0] d0, input logic [15:0] d1);
    wm[0] = r0[2]; rm[0] = r0[1]; iv[0] = r0[0];
    wm[1] = r1[2]; rm[1] = r1[1]; iv[1] = r1[0];
    bico[0] = a0; bico[1] = a1;
    found[0] = f0; found[1] = f1;
    sdata[0] = d0; sdata[1] = d1;
  endtask

  task automatic runCycle();
    @(posedge clk);
    if (!rst_n) modelReset();
    else        modelEdge();
    @(negedge clk);
    checkAll();
  endtask

  task automatic drainAll();
    for (int i = 0; i < 30 && (m_busy[0] || m_busy[1]); i++) runCycle();
    checkOutput("drain_timeout", 64'(m_busy[0] | m_busy[1]), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit seen;
    rst_n = 1'b0;
    applyStimulus(3'b000, 3'b000, 11'h0, 11'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    modelReset();
    repeat (2) @(negedge clk);
    checkAll();
    rst_n = 1'b1;

    $display("[TB] simultaneous read misses and round-robin");
    applyStimulus(3'b010, 3'b010, 11'h011, 11'h022, 1'b1, 1'b1, 16'h1234, 16'h5678);
    runCycle();
    runCycle();
    checkOutput("t4_first_grant", {if1_0.grant, if1_1.grant}, 64'b10);
    runCycle();
    runCycle();
    applyStimulus(3'b000, 3'b010, 11'h011, 11'h022, 1'b1, 1'b1, 16'h1234, 16'h5678);
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      runCycle();
      seen = if1_1.grant;
    end
    checkOutput("t4_second_grant", 64'(seen), 64'd1);
    applyStimulus(3'b000, 3'b000, 11'h0, 11'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    drainAll();
    applyStimulus(3'b010, 3'b010, 11'h033, 11'h044, 1'b0, 1'b0, 16'h0, 16'h0);
    runCycle();
    runCycle();
    checkOutput("t4_third_grant", {if1_0.grant, if1_1.grant}, 64'b10);
    applyStimulus(3'b000, 3'b000, 11'h0, 11'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    drainAll();

    $display("[TB] cpu0 read miss hits in cpu1");
    applyStimulus(3'b010, 3'b000, 11'h055, 11'h0, 1'b0, 1'b1, 16'h0, 16'hBEEF);
    runCycle();
    checkOutput("t1_search1", 64'(if1_1.cpu_search), 64'd1);
    checkOutput("t1_boci1", 64'(if1_1.BOCI), 64'h0855);
    runCycle();
    checkOutput("t1_grant0", 64'(if1_0.grant), 64'd1);
    checkOutput("t1_datasel0", 64'(if1_0.cpu_datasel), 64'd1);
    checkOutput("t1_data0", 64'(if1_0.other_proc_data), 64'hBEEF);
    checkOutput("t1_noinv1", 64'(if1_1.invalidate_from_other_cpu), 64'd0);
    applyStimulus(3'b000, 3'b000, 11'h0, 11'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    drainAll();

    $display("[TB] cpu1 write miss misses in cpu0");
    applyStimulus(3'b000, 3'b100, 11'h0, 11'h3A0, 1'b0, 1'b0, 16'h0, 16'h0);
    runCycle();
    checkOutput("t2_boci0", 64'(if1_0.BOCI), 64'h13A0);
    runCycle();
    checkOutput("t2_grant1", 64'(if1_1.grant), 64'd1);
    checkOutput("t2_datasel1", 64'(if1_1.cpu_datasel), 64'd2);
    checkOutput("t2_inv0", 64'(if1_0.invalidate_from_other_cpu), 64'd1);
    applyStimulus(3'b000, 3'b000, 11'h0, 11'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    drainAll();

    $display("[TB] cpu0 upgrade");
    applyStimulus(3'b001, 3'b000, 11'h123, 11'h0, 1'b0, 1'b1, 16'h0, 16'h7777);
    runCycle();
    checkOutput("t3_boci1_op", 64'(if1_1.BOCI[12:11]), 64'd3);
    runCycle();
    checkOutput("t3_grant0", 64'(if1_0.grant), 64'd1);
    checkOutput("t3_datasel0", 64'(if1_0.cpu_datasel), 64'd0);
    checkOutput("t3_inv1", 64'(if1_1.invalidate_from_other_cpu), 64'd1);
    applyStimulus(3'b000, 3'b000, 11'h0, 11'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    drainAll();

    $display("[TB] three-cycle snoop samples found on the last edge only");
    applyStimulus(3'b010, 3'b000, 11'h2AA, 11'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    runCycle();
    checkOutput("t5_search_c1", 64'(if3_1.cpu_search), 64'd1);
    applyStimulus(3'b010, 3'b000, 11'h2AA, 11'h0, 1'b0, 1'b1, 16'h0, 16'h1111);
    runCycle();
    checkOutput("t5_search_c2", 64'(if3_1.cpu_search), 64'd1);
    runCycle();
    checkOutput("t5_search_c3", 64'(if3_1.cpu_search), 64'd1);
    checkOutput("t5_no_early_grant", 64'(if3_0.grant), 64'd0);
    applyStimulus(3'b010, 3'b000, 11'h2AA, 11'h0, 1'b0, 1'b0, 16'h0, 16'h2222);
    runCycle();
    checkOutput("t5_grant0", 64'(if3_0.grant), 64'd1);
    checkOutput("t5_datasel0", 64'(if3_0.cpu_datasel), 64'd2);
    checkOutput("t5_data0", 64'(if3_0.other_proc_data), 64'd0);
    applyStimulus(3'b000, 3'b000, 11'h0, 11'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    drainAll();

    $display("[TB] reset during snoop");
    applyStimulus(3'b000, 3'b010, 11'h0, 11'h155, 1'b1, 1'b0, 16'hCAFE, 16'h0);
    runCycle();
    #2;
    rst_n = 1'b0;
    modelReset();
    #1;
    for (int m = 0; m < 2; m++)
      for (int c = 0; c < 2; c++)
        checkOutput($sformatf("rst_async_lat%0d_cpu%0d", lat_of[m], c), 64'(obs[m][c]), 64'd0);
    applyStimulus(3'b000, 3'b000, 11'h0, 11'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    runCycle();
    runCycle();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      runCycle();
      checkOutput("rst_no_grant", {if1_0.grant, if1_1.grant, if3_0.grant, if3_1.grant}, 64'd0);
    end
    applyStimulus(3'b010, 3'b000, 11'h066, 11'h0, 1'b0, 1'b1, 16'h0, 16'hABCD);
    runCycle();
    runCycle();
    checkOutput("rst_fresh_grant0", 64'(if1_0.grant), 64'd1);
    applyStimulus(3'b000, 3'b000, 11'h0, 11'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    drainAll();

    $display("[TB] randomized traffic");
    for (int i = 0; i < 600; i++) begin
      applyStimulus({($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0)},
                    {($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0)},
                    11'($urandom), 11'($urandom), 1'($urandom), 1'($urandom),
                    16'($urandom), 16'($urandom));
      runCycle();
    end
    applyStimulus(3'b000, 3'b000, 11'h0, 11'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    drainAll();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
